// File: rtl/logic_fu_cdb.sv
// Logic functional unit with a common-data-bus result buffer.
//
// An accepted operation is evaluated bitwise and latched into a single execute
// register; on the next edge it moves unconditionally into a DEPTH-entry FIFO.
// The FIFO head is offered on the CDB and pops on every granted cycle.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   issue_valid / issue_ready    issue handshake from the reservation station
//   issue_op, issue_a, issue_b   opcode and 32-bit operands
//   issue_tag                    destination tag
//   flush                        synchronous squash of all in-flight work
//   cdb_req / cdb_gnt            bus request and arbiter grant
//   cdb_valid, cdb_tag, cdb_data broadcast (zeroed when not valid)
//   busy                         any operation in flight
module logic_fu_cdb #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [2:0]       issue_op,
    input  logic [31:0]      issue_a,
    input  logic [31:0]      issue_b,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             flush,
    output logic             cdb_req,
    input  logic             cdb_gnt,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    output logic             busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    logic             exec_v_q, exec_v_d;
    logic [TAG_W-1:0] exec_tag_q, exec_tag_d;
    logic [31:0]      exec_data_q, exec_data_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Storage is not reset: cdb_tag/cdb_data are gated by cdb_valid.
    logic [31:0]      mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];

    logic [31:0]  result;
    logic [CNT_W:0] occupancy;
    logic         accept;
    logic         push;
    logic         pop;

    // Readiness depends only on state, never on grant or issue_valid.
    assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, exec_v_q};
    assign issue_ready = occupancy < DEPTH_EXT;

    assign cdb_req   = (count_q != '0);
    assign cdb_valid = cdb_req & cdb_gnt;
    assign cdb_tag   = cdb_valid ? mem_tag[rd_ptr_q]  : '0;
    assign cdb_data  = cdb_valid ? mem_data[rd_ptr_q] : '0;
    assign busy      = exec_v_q | cdb_req;

    assign accept = issue_valid & issue_ready & ~flush;
    // The execute entry always finds room: readiness reserved a slot for it.
    assign push   = exec_v_q & ~flush;
    assign pop    = cdb_valid & ~flush;

    always_comb begin
        result = '0;
        case (issue_op)
            3'b000: result = issue_a & issue_b;
            3'b001: result = issue_a | issue_b;
            3'b010: result = issue_a ^ issue_b;
            3'b011: result = ~(issue_a & issue_b);
            3'b100: result = ~(issue_a | issue_b);
            3'b101: result = ~(issue_a ^ issue_b);
            3'b110: result = ~issue_a;
            3'b111: result = issue_a;
        endcase
    end

    always_comb begin
        exec_v_d    = accept;
        exec_tag_d  = accept ? issue_tag : exec_tag_q;
        exec_data_d = accept ? result : exec_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_v_q    <= 1'b0;
            exec_tag_q  <= '0;
            exec_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            exec_v_q    <= exec_v_d;
            exec_tag_q  <= exec_tag_d;
            exec_data_q <= exec_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= exec_data_q;
            mem_tag[wr_ptr_q]  <= exec_tag_q;
        end
    end

endmodule

// File: tb/tb_logic_fu_cdb.sv
module tb_logic_fu_cdb;

    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic [2:0]       issue_op;
    logic [31:0]      issue_a;
    logic [31:0]      issue_b;
    logic [TAG_W-1:0] issue_tag;
    logic             flush;
    logic             cdb_req;
    logic             cdb_gnt;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             busy;

    int checks;
    int errors;

    logic [31:0] exp_ops [8];

    logic_fu_cdb #(.TAG_W(TAG_W), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_tag   (issue_tag),
        .flush       (flush),
        .cdb_req     (cdb_req),
        .cdb_gnt     (cdb_gnt),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_a = '0; issue_b = '0;
        issue_tag = '0; flush = 1'b0; cdb_gnt = 1'b1;
        #2;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", issue_ready); end
        checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", cdb_req); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", cdb_valid); end
        checks++; if (cdb_tag !== 4'h0) begin errors++; $display("FAIL rst_tag: got %h want 0", cdb_tag); end
        checks++; if (cdb_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", cdb_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_gnt_noeffect: busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        cdb_gnt = 1'b1;
        issue_valid = 1'b1; issue_op = 3'b011; issue_a = 32'hFFFF_0000; issue_b = 32'h0F0F_0F0F;
        issue_tag = 4'd3;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", issue_ready); end
        step();
        issue_valid = 1'b0;
        #1;
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", cdb_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        step();
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", cdb_valid); end
        checks++; if (cdb_tag !== 4'd3) begin errors++; $display("FAIL single_tag: got %h want 3", cdb_tag); end
        checks++; if (cdb_data !== 32'hF0F0_FFFF) begin errors++; $display("FAIL single_data: got %h want f0f0ffff", cdb_data); end
        step();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b want 0", cdb_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_all_ops();
        exp_ops[0] = 32'h0000_5555; exp_ops[1] = 32'hAAAA_FFFF;
        exp_ops[2] = 32'hAAAA_AAAA; exp_ops[3] = 32'hFFFF_AAAA;
        exp_ops[4] = 32'h5555_0000; exp_ops[5] = 32'h5555_5555;
        exp_ops[6] = 32'h5555_AAAA; exp_ops[7] = 32'hAAAA_5555;
        cdb_gnt = 1'b1; issue_a = 32'hAAAA_5555; issue_b = 32'h0000_FFFF;
        for (int i = 0; i < 11; i++) begin
            issue_valid = (i < 8);
            issue_op = 3'(i);
            issue_tag = 4'(i);
            #1;
            if (i < 8) begin
                checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL ops_ready[%0d]: got %b want 1", i, issue_ready); end
            end
            if (i >= 2 && i < 10) begin
                checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'(i - 2) || cdb_data !== exp_ops[i - 2]) begin
                    errors++;
                    $display("FAIL ops_result[%0d]: got v=%b tag=%h data=%h want v=1 tag=%h data=%h",
                             i - 2, cdb_valid, cdb_tag, cdb_data, 4'(i - 2), exp_ops[i - 2]);
                end
            end
            if (i == 10) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ops_idle: got %b want 0", busy); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        cdb_gnt = 1'b0; issue_op = 3'b111; issue_b = 32'h0;
        for (int i = 0; i < 6; i++) begin
            issue_valid = 1'b1;
            issue_tag = 4'(i < 5 ? i + 1 : 5);
            issue_a = 32'h1111_1111 * (i < 5 ? i + 1 : 5);
            #1;
            checks++; if (issue_ready !== (i < 4)) begin errors++; $display("FAIL bp_ready[%0d]: got %b want %b", i, issue_ready, (i < 4)); end
            if (i >= 4) begin
                checks++; if (cdb_req !== 1'b1 || cdb_valid !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got req=%b v=%b want req=1 v=0", i, cdb_req, cdb_valid); end
            end
            step();
        end
        cdb_gnt = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) issue_valid = 1'b0;
            #1;
            if (k <= 5) begin
                checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'(k) || cdb_data !== 32'h1111_1111 * k) begin
                    errors++;
                    $display("FAIL bp_bcast[%0d]: got v=%b tag=%h data=%h want v=1 tag=%h data=%h",
                             k, cdb_valid, cdb_tag, cdb_data, 4'(k), 32'h1111_1111 * k);
                end
            end else begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", busy); end
            end
            if (k == 1) begin
                checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", issue_ready); end
            end
            if (k == 2) begin
                checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen: got %b want 1", issue_ready); end
            end
            step();
        end
    endtask

    task automatic test_stream();
        logic [31:0] a_v, exp_v;
        cdb_gnt = 1'b1; issue_b = 32'hFFFF_0000;
        for (int i = 0; i < 23; i++) begin
            issue_valid = (i < 20);
            issue_op = (i % 2 == 0) ? 3'b010 : 3'b000;
            issue_a = 32'h1234_0000 + 32'(i * 32'h0001_0101);
            issue_tag = 4'(i);
            #1;
            if (i < 20) begin
                checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, issue_ready); end
            end
            if (i >= 2 && i < 22) begin
                a_v = 32'h1234_0000 + 32'((i - 2) * 32'h0001_0101);
                exp_v = ((i - 2) % 2 == 0) ? (a_v ^ 32'hFFFF_0000) : (a_v & 32'hFFFF_0000);
                checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'(i - 2) || cdb_data !== exp_v) begin
                    errors++;
                    $display("FAIL stream[%0d]: got v=%b tag=%h data=%h want v=1 tag=%h data=%h",
                             i - 2, cdb_valid, cdb_tag, cdb_data, 4'(i - 2), exp_v);
                end
            end
            if (i == 22) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle: got %b want 0", busy); end
            end
            step();
        end
    endtask

    task automatic test_flush();
        cdb_gnt = 1'b0; issue_op = 3'b111; issue_b = 32'h0;
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1; issue_tag = 4'(i + 1); issue_a = 32'hC0DE_0000 + 32'(i);
            step();
        end
        cdb_gnt = 1'b1; flush = 1'b1; issue_tag = 4'd9;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_pre: got %b want 1", busy); end
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'd1) begin errors++; $display("FAIL flush_cycle_valid: got v=%b tag=%h want v=1 tag=1", cdb_valid, cdb_tag); end
        step();
        flush = 1'b0; issue_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", issue_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_nobcast[%0d]: got %b want 0", i, cdb_valid); end
            step();
        end
    endtask

    task automatic test_async_reset();
        cdb_gnt = 1'b0; issue_op = 3'b111;
        issue_valid = 1'b1; issue_tag = 4'd1; issue_a = 32'h1;
        step();
        issue_tag = 4'd2; issue_a = 32'h2;
        step();
        issue_valid = 1'b0;
        step();
        checks++; if (cdb_req !== 1'b1) begin errors++; $display("FAIL ar_pre_req: got %b want 1", cdb_req); end
        #2;
        rst_n = 1'b0; cdb_gnt = 1'b1;
        #1;
        checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL ar_req: got %b want 0", cdb_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", busy); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", issue_ready); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", cdb_valid); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (cdb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_after[%0d]: got v=%b busy=%b want 0 0", i, cdb_valid, busy); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_all_ops();
        test_backpressure();
        test_stream();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_fu_cdb.md
LOGIC_FU_CDB -- requirements
Module: logic_fu_cdb

Interface
REQ-001 The module SHALL have parameter TAG_W, default 4, meaning the reservation-station tag width.
REQ-002 The module SHALL have parameter DEPTH, default 4, minimum 2, meaning the result-buffer entry count.
REQ-003 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous and active-low.
REQ-005 ISSUE_VALID  input  1  the reservation station presents an operation.
REQ-006 ISSUE_READY  output  1  the unit can accept an operation this cycle.
REQ-007 ISSUE_OP  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 pass A.
REQ-008 ISSUE_A, ISSUE_B  input  32 each  operands.
REQ-009 ISSUE_TAG  input  TAG_W  destination tag.
REQ-010 FLUSH  input  1  synchronous squash of all in-flight work.
REQ-011 CDB_REQ  output  1  request for the common data bus.
REQ-012 CDB_GNT  input  1  bus grant from the CDB arbiter.
REQ-013 CDB_VALID  output  1  broadcast is valid this cycle.
REQ-014 CDB_TAG  output  TAG_W  broadcast tag.
REQ-015 CDB_DATA  output  32  broadcast result.
REQ-016 BUSY  output  1  the unit holds any in-flight operation.

Function
REQ-017 An operation SHALL be accepted on a rising edge where ISSUE_VALID=1, ISSUE_READY=1 and FLUSH=0.
REQ-018 The accepted result SHALL be computed bitwise over all 32 bits per ISSUE_OP; ISSUE_B SHALL be ignored for opcodes 110 and 111.
REQ-019 The result and tag SHALL be latched into a single execute register (exec_v=1) at the accept edge.
REQ-020 On the following edge, an exec_v entry SHALL move into the FIFO tail unconditionally; it SHALL never be dropped.
REQ-021 ISSUE_READY SHALL equal 1 when (count + exec_v) < DEPTH, where count is the FIFO occupancy.
REQ-022 ISSUE_READY SHALL have no combinational dependence on CDB_GNT or ISSUE_VALID.
REQ-023 CDB_REQ SHALL equal (count != 0).
REQ-024 CDB_VALID SHALL equal CDB_REQ AND CDB_GNT.
REQ-025 When CDB_VALID=1, CDB_TAG and CDB_DATA SHALL present the FIFO head; otherwise both SHALL be 0.
REQ-026 At an edge where CDB_VALID=1, the FIFO head SHALL pop; CDB_GNT while CDB_REQ=0 SHALL have no effect.
REQ-027 FIFO order SHALL equal issue order; read and write pointers SHALL wrap modulo DEPTH.
REQ-028 A simultaneous push and pop SHALL leave count unchanged and SHALL preserve data correctly, including when count=DEPTH-1 and when count=1.
REQ-029 Minimum issue-to-broadcast latency SHALL be 2 cycles: accept at edge N, FIFO entry at edge N+1, CDB_REQ high in the cycle after edge N+1.
REQ-030 With CDB_GNT held at 1 and DEPTH>=3, sustained throughput SHALL be one operation per cycle.
REQ-031 FLUSH=1 at an edge SHALL clear exec_v, count and the pointers.
REQ-032 FLUSH=1 SHALL discard any issue or pop in the same cycle; CDB_VALID still follows REQ-024 in that cycle.
REQ-033 BUSY SHALL equal exec_v OR (count != 0).

Reset
REQ-034 While RESET_N=0, exec_v, count and the pointers SHALL be 0 immediately, without waiting for a clock edge.
REQ-035 While RESET_N=0, CDB_REQ, CDB_VALID, CDB_TAG, CDB_DATA and BUSY SHALL be 0, and ISSUE_READY SHALL be 1.
REQ-036 FIFO data storage SHALL need no reset; outputs SHALL never expose unreset data (per REQ-025).
REQ-037 Reset asserted mid-operation SHALL discard all in-flight results; no broadcast SHALL occur for them after release.

Verification
REQ-038 Single op: NAND, A=0xFFFF0000, B=0x0F0F0F0F, tag 3, GNT=1 -> CDB_VALID exactly 2 cycles after accept, tag 3, data 0xF0F0FFFF.
REQ-039 All opcodes: A=0xAAAA5555, B=0x0000FFFF ->
- AND 0x00005555
- OR 0xAAAAFFFF
- XOR 0xAAAAAAAA
- NAND 0xFFFFAAAA
- NOR 0x55550000
- XNOR 0x55555555
- NOT 0x5555AAAA
- pass 0xAAAA5555
REQ-040 Backpressure: GNT=0, issue tags 1..5 back-to-back -> 4 accepted, ISSUE_READY low; raise GNT -> broadcasts tags 1,2,3,4 on consecutive cycles; tag 5 then accepted.
REQ-041 Streaming: GNT=1, 20 back-to-back ops -> 20 broadcasts on consecutive cycles, in order, with pointer wrap exercised.
REQ-042 Flush: 3 ops in flight, GNT=0, FLUSH pulse -> BUSY=0 next cycle; no broadcast follows after GNT=1.
REQ-043 Async reset: RESET_N low mid-cycle with count=2 -> CDB_REQ=0 and BUSY=0 before the next edge, ISSUE_READY=1.
